// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   localparam int INST_BYTES = 4;

   // Counter width able to hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_credit_counter.sv
// Buffer occupancy and in-flight request counters plus the issue permit.
// Together they form the credit pool that keeps the buffer from overflowing.
module fetch_credit_counter
   import fetch_pkg::*;
#(
   parameter int BUFFER_DEPTH    = 8,
   parameter int MAX_OUTSTANDING = 2,
   localparam int CW             = cnt_width(BUFFER_DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush_i,
   input  logic          write_i,
   input  logic          pop_i,
   input  logic          fire_i,
   input  logic          resp_i,
   output logic [CW-1:0] occ_o,
   output logic [CW-1:0] outstanding_o,
   output logic          permit_o
);

   logic [CW-1:0] occ_q, occ_d;
   logic [CW-1:0] out_q, out_d;
   logic          resp_ok;
   logic [CW:0]   credits_used;

   // A response with nothing in flight is a protocol error and is ignored.
   assign resp_ok      = resp_i && (out_q != '0);
   assign credits_used = {1'b0, occ_q} + {1'b0, out_q};

   // Next-state for both counters; a flush empties the buffer and ignores pops.
   always_comb begin
      occ_d = occ_q;
      out_d = out_q + CW'(fire_i) - CW'(resp_ok);
      if (flush_i)
         occ_d = '0;
      else
         occ_d = occ_q + CW'(write_i) - CW'(pop_i && (occ_q != '0));
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q <= '0;
         out_q <= '0;
      end else begin
         occ_q <= occ_d;
         out_q <= out_d;
      end
   end

   assign permit_o      = (out_q < CW'(MAX_OUTSTANDING)) &&
                          (credits_used < (CW+1)'(BUFFER_DEPTH));
   assign occ_o         = occ_q;
   assign outstanding_o = out_q;

   a_credit_bound: assert property (@(posedge clk) disable iff (reset)
      credits_used <= (CW+1)'(BUFFER_DEPTH));
   a_resp_in_flight: assert property (@(posedge clk) disable iff (reset)
      resp_i |-> (out_q != '0));

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC and FSM, issues in-order
// memory requests within the credit budget, and drops stale responses after
// a redirect.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter int                ADDR_WIDTH      = 32,
   parameter int                INST_WIDTH      = 32,
   parameter int                BUFFER_DEPTH    = 8,
   parameter int                MAX_OUTSTANDING = 2,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
   localparam int               CW              = cnt_width(BUFFER_DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_en,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   input  logic                  buf_pop,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_resp_valid,
   input  logic [INST_WIDTH-1:0] imem_resp_data,
   output logic                  buf_write_en,
   output logic [INST_WIDTH-1:0] buf_data,
   output logic                  buf_flush,
   output logic [CW-1:0]         buf_count,
   output logic                  busy
);

   fetch_state_e          state_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [CW-1:0]         drop_q;
   logic [CW-1:0]         drop_d;
   logic [CW-1:0]         occ, outstanding;
   logic                  permit, issue, fire, write;

   assign issue = (state_q == FETCH) && fetch_en && !redirect_valid && permit;
   assign fire  = issue && imem_req_ready;
   assign write = imem_resp_valid && (drop_q == '0) && !redirect_valid;

   // Responses still in flight at a redirect are stale; one arriving this
   // very cycle is already accounted for.
   assign drop_d = (imem_resp_valid && (outstanding != '0)) ? outstanding - CW'(1)
                                                            : outstanding;

   fetch_credit_counter #(
      .BUFFER_DEPTH    (BUFFER_DEPTH),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_credit (
      .clk           (clk),
      .reset         (reset),
      .flush_i       (redirect_valid),
      .write_i       (write),
      .pop_i         (buf_pop),
      .fire_i        (fire),
      .resp_i        (imem_resp_valid),
      .occ_o         (occ),
      .outstanding_o (outstanding),
      .permit_o      (permit)
   );

   // FSM, fetch PC and stale-response drop counter; redirect has top priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         drop_q  <= '0;
      end else if (redirect_valid) begin
         pc_q    <= redirect_pc;
         drop_q  <= drop_d;
         if (drop_d != '0)  state_q <= DRAIN;
         else if (fetch_en) state_q <= FETCH;
         else               state_q <= IDLE;
      end else begin
         if (fire)
            pc_q <= pc_q + ADDR_WIDTH'(INST_BYTES);
         if (imem_resp_valid && (drop_q != '0))
            drop_q <= drop_q - CW'(1);
         case (state_q)
            IDLE:    if (fetch_en) state_q <= FETCH;
            FETCH:   if (!fetch_en) state_q <= IDLE;
            DRAIN:   if (imem_resp_valid && (drop_q == CW'(1)))
                        state_q <= fetch_en ? FETCH : IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Outputs are forced quiet while reset is held.
   assign imem_req_valid = !reset && issue;
   assign imem_req_addr  = reset ? RESET_PC : pc_q;
   assign buf_write_en   = !reset && write;
   assign buf_data       = reset ? '0 : imem_resp_data;
   assign buf_flush      = !reset && redirect_valid;
   assign buf_count      = reset ? '0 : occ;
   assign busy           = !reset && (outstanding != '0);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed table-driven bench for fetch_controller.
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_en, redirect_valid, buf_pop;
   logic [31:0] redirect_pc;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        buf_write_en, buf_flush, busy;
   logic [31:0] buf_data;
   logic [3:0]  buf_count;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        fen, rdy, pop, rdr;
      logic [31:0] rpc;
      logic        rsp;
      logic [31:0] rdat;
      logic        e_vld;
      logic [31:0] e_addr;
      logic        e_we;
      logic [3:0]  e_cnt;
      logic        e_fl, e_busy;
   } vec_t;

   vec_t tbl[$];

   fetch_controller #(
      .ADDR_WIDTH(32), .INST_WIDTH(32), .BUFFER_DEPTH(8),
      .MAX_OUTSTANDING(2), .RESET_PC(32'h0)
   ) dut (
      .clk(clk), .reset(reset), .fetch_en(fetch_en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .buf_pop(buf_pop), .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .buf_write_en(buf_write_en), .buf_data(buf_data),
      .buf_flush(buf_flush), .buf_count(buf_count), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic row(input logic fen, rdy, pop, rdr, input logic [31:0] rpc, input logic rsp,
                      input logic vld, input logic [31:0] addr, input logic we,
                      input logic [3:0] cnt, input logic fl, busy_e);
      vec_t v;
      v.fen = fen; v.rdy = rdy; v.pop = pop; v.rdr = rdr; v.rpc = rpc; v.rsp = rsp;
      v.rdat = 32'hD000_0000 + 32'(tbl.size());
      v.e_vld = vld; v.e_addr = addr; v.e_we = we; v.e_cnt = cnt;
      v.e_fl = fl; v.e_busy = busy_e;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic fen, rdy, pop, rdr, input logic [31:0] rpc,
                        input logic rsp, input logic [31:0] rdat);
      fetch_en = fen; imem_req_ready = rdy; buf_pop = pop;
      redirect_valid = rdr; redirect_pc = rpc;
      imem_resp_valid = rsp; imem_resp_data = rdat;
   endtask

   task automatic chk_all(input string tag, input logic vld, input logic [31:0] addr,
                          input logic we, input logic [3:0] cnt, input logic fl,
                          input logic busy_e);
      chk({tag, "_vld"},   32'(imem_req_valid), 32'(vld));
      chk({tag, "_addr"},  imem_req_addr,       addr);
      chk({tag, "_we"},    32'(buf_write_en),   32'(we));
      chk({tag, "_cnt"},   32'(buf_count),      32'(cnt));
      chk({tag, "_flush"}, 32'(buf_flush),      32'(fl));
      chk({tag, "_busy"},  32'(busy),           32'(busy_e));
   endtask

   initial begin
      // Fill phase: 1-cycle memory, no pops, up to the full buffer.
      row(1,1,0,0,0,0, 0,32'h00,0,0,0,0);
      row(1,1,0,0,0,0, 1,32'h00,0,0,0,0);
      row(1,1,0,0,0,1, 1,32'h04,1,0,0,1);
      row(1,1,0,0,0,1, 1,32'h08,1,1,0,1);
      row(1,1,0,0,0,1, 1,32'h0C,1,2,0,1);
      row(1,1,0,0,0,1, 1,32'h10,1,3,0,1);
      row(1,1,0,0,0,1, 1,32'h14,1,4,0,1);
      row(1,1,0,0,0,1, 1,32'h18,1,5,0,1);
      row(1,1,0,0,0,1, 1,32'h1C,1,6,0,1);
      row(1,1,0,0,0,1, 0,32'h20,1,7,0,1);
      row(1,1,0,0,0,0, 0,32'h20,0,8,0,0);
      row(1,1,0,0,0,0, 0,32'h20,0,8,0,0);
      // One pop from full frees exactly one request.
      row(1,1,1,0,0,0, 0,32'h20,0,8,0,0);
      row(1,1,0,0,0,0, 1,32'h20,0,7,0,0);
      row(1,1,0,0,0,0, 0,32'h24,0,7,0,1);
      row(1,1,0,0,0,1, 0,32'h24,1,7,0,1);
      // Free two slots, get two in flight, then redirect.
      row(1,1,1,0,0,0, 0,32'h24,0,8,0,0);
      row(1,1,1,0,0,0, 1,32'h24,0,7,0,0);
      row(1,1,0,0,0,0, 1,32'h28,0,6,0,1);
      row(1,1,0,1,32'h100,0, 0,32'h2C,0,6,1,1);
      row(1,1,0,0,0,0, 0,32'h100,0,0,0,1);
      row(1,1,0,0,0,1, 0,32'h100,0,0,0,1);
      row(1,1,0,0,0,1, 0,32'h100,0,0,0,1);
      row(1,1,0,0,0,0, 1,32'h100,0,0,0,0);
      // Redirect coincident with the only in-flight response.
      row(1,1,0,1,32'h200,1, 0,32'h104,0,0,1,1);
      // Ready low for five cycles: request must hold.
      for (int k = 0; k < 5; k++) row(1,0,0,0,0,0, 1,32'h200,0,0,0,0);
      row(1,1,0,0,0,0, 1,32'h200,0,0,0,0);
      row(1,1,0,0,0,0, 1,32'h204,0,0,0,1);
      // fetch_en drops: in-flight responses still land; pop at 0 ignored,
      // write+pop together leaves count unchanged.
      row(0,1,1,0,0,1, 0,32'h208,1,0,0,1);
      row(0,1,1,0,0,1, 0,32'h208,1,1,0,1);
      row(0,1,0,0,0,0, 0,32'h208,0,1,0,0);
      // Restart and build two outstanding, then redirect into DRAIN.
      row(1,1,0,0,0,0, 0,32'h208,0,1,0,0);
      row(1,1,0,0,0,0, 1,32'h208,0,1,0,0);
      row(1,1,0,0,0,0, 1,32'h20C,0,1,0,1);
      row(1,1,0,1,32'h300,0, 0,32'h210,0,1,1,1);
      row(1,1,0,0,0,0, 0,32'h300,0,0,0,1);

      // Reset state, outputs quiet even with live inputs.
      reset = 1'b1;
      drive(1,1,1,1,32'h40,1,32'hDEAD_BEEF);
      @(negedge clk);
      @(negedge clk);
      #2;
      chk_all("rst", 0, 32'h0, 0, 0, 0, 0);
      chk("rst_data", buf_data, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      drive(0,0,0,0,0,0,0);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         drive(tbl[i].fen, tbl[i].rdy, tbl[i].pop, tbl[i].rdr, tbl[i].rpc,
               tbl[i].rsp, tbl[i].rdat);
         #2;
         chk_all($sformatf("row%0d", i), tbl[i].e_vld, tbl[i].e_addr, tbl[i].e_we,
                 tbl[i].e_cnt, tbl[i].e_fl, tbl[i].e_busy);
         if (tbl[i].e_we) chk($sformatf("row%0d_data", i), buf_data, tbl[i].rdat);
      end

      // Reset in DRAIN with two outstanding, with active inputs.
      @(negedge clk);
      reset = 1'b1;
      drive(1,1,1,1,32'h400,1,32'hBAD0_0001);
      #2;
      chk_all("drain_rst", 0, 32'h0, 0, 0, 0, 0);
      chk("drain_rst_data", buf_data, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      drive(0,0,0,0,0,0,0);
      #2;
      chk_all("post_rst", 0, 32'h0, 0, 0, 0, 0);
      @(negedge clk);
      drive(1,1,0,0,0,0,0);
      #2;
      chk_all("post_rst_idle", 0, 32'h0, 0, 0, 0, 0);
      @(negedge clk);
      #2;
      chk_all("post_rst_issue", 1, 32'h0, 0, 0, 0, 0);
      // Drop counter must be clear: first response is written.
      @(negedge clk);
      drive(1,1,0,0,0,1,32'hC0DE_0000);
      #2;
      chk_all("post_rst_resp", 1, 32'h4, 1, 0, 0, 1);
      chk("post_rst_data", buf_data, 32'hC0DE_0000);

      @(negedge clk);
      drive(0,0,0,0,0,0,0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
